// File: rtl/set_key_ctrl.sv
// Set-key controller: turns debounced set buttons into one-clk field increment
// pulses, with tap, hold/auto-repeat and chord lockout behaviour.
module set_key_ctrl #(
  parameter int N_FIELDS     = 3,
  parameter int HOLD_TICKS   = 8,
  parameter int REPEAT_TICKS = 2,
  parameter int TICK_CNT_W   = 8,
  localparam int IDX_W       = $clog2(N_FIELDS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                tick,
  input  logic [N_FIELDS-1:0] set_in,
  output logic [N_FIELDS-1:0] inc_pulse,
  output logic [IDX_W-1:0]    active_field,
  output logic                chord
);

  typedef enum logic [1:0] {IDLE, ARMED, REPEAT, LOCKOUT} state_t;

  state_t                state;
  logic [TICK_CNT_W-1:0] hold_cnt;
  logic [TICK_CNT_W-1:0] rep_cnt;

  // Decode the button vector: none / exactly one (with its index) / several.
  logic             any_key, multi_key, one_key;
  logic [IDX_W-1:0] key_idx;

  always_comb begin
    any_key   = 1'b0;
    multi_key = 1'b0;
    key_idx   = '0;
    for (int i = 0; i < N_FIELDS; i++) begin
      if (set_in[i]) begin
        multi_key = multi_key | any_key;
        any_key   = 1'b1;
        key_idx   = IDX_W'(i);
      end
    end
    one_key = any_key & ~multi_key;
  end

  logic [N_FIELDS-1:0] cur_bit;
  logic                slide;
  logic                hold_done, rep_done;

  assign cur_bit   = N_FIELDS'(1) << active_field;
  assign slide     = one_key && (key_idx != active_field);
  assign hold_done = (hold_cnt == TICK_CNT_W'(HOLD_TICKS - 1));
  assign rep_done  = (rep_cnt == TICK_CNT_W'(REPEAT_TICKS - 1));

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state        <= IDLE;
      inc_pulse    <= '0;
      active_field <= '0;
      chord        <= 1'b0;
      hold_cnt     <= '0;
      rep_cnt      <= '0;
    end else begin
      inc_pulse <= '0;
      case (state)
        IDLE: begin
          if (one_key) begin
            state        <= ARMED;
            active_field <= key_idx;
            hold_cnt     <= '0;
          end else if (multi_key) begin
            state <= LOCKOUT;
            chord <= 1'b1;
          end
        end
        ARMED: begin
          // Release beats a coincident tick so a tap never double-counts.
          if (!any_key) begin
            inc_pulse    <= cur_bit;
            state        <= IDLE;
            active_field <= '0;
            hold_cnt     <= '0;
          end else if (multi_key) begin
            state        <= LOCKOUT;
            chord        <= 1'b1;
            active_field <= '0;
            hold_cnt     <= '0;
          end else if (slide) begin
            inc_pulse    <= cur_bit;
            active_field <= key_idx;
            hold_cnt     <= '0;
          end else if (tick) begin
            if (hold_done) begin
              inc_pulse <= cur_bit;
              state     <= REPEAT;
              hold_cnt  <= '0;
              rep_cnt   <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        REPEAT: begin
          if (!any_key) begin
            state        <= IDLE;
            active_field <= '0;
            rep_cnt      <= '0;
          end else if (multi_key) begin
            state        <= LOCKOUT;
            chord        <= 1'b1;
            active_field <= '0;
            rep_cnt      <= '0;
          end else if (slide) begin
            state        <= ARMED;
            active_field <= key_idx;
            hold_cnt     <= '0;
            rep_cnt      <= '0;
          end else if (tick) begin
            if (rep_done) begin
              inc_pulse <= cur_bit;
              rep_cnt   <= '0;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
          end
        end
        LOCKOUT: begin
          // Only a full release re-arms; dropping to one key is not enough.
          if (!any_key) begin
            state <= IDLE;
            chord <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          chord <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_set_key_ctrl.sv
// Directed bench for set_key_ctrl: tap, hold/repeat, slide, chord, enable drop.
module tb_set_key_ctrl;
  localparam int N = 3;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset, enable, tick;
  logic [N-1:0]  set_in;
  logic [N-1:0]  inc_pulse;
  logic [IW-1:0] active_field;
  logic          chord;

  int n_chk = 0;
  int n_err = 0;
  int pc[N];
  int viol = 0;

  set_key_ctrl #(.N_FIELDS(N), .HOLD_TICKS(4), .REPEAT_TICKS(2), .TICK_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .tick(tick), .set_in(set_in),
    .inc_pulse(inc_pulse), .active_field(active_field), .chord(chord)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < N; i++) pc[i] = 0;

  // Count the pulse held during the previous cycle at each rising edge.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) if (inc_pulse[i] === 1'b1) pc[i] = pc[i] + 1;
    if ($countones(inc_pulse) > 1) viol = viol + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_tick();
    repeat (9) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  function automatic int tot();
    return pc[0] + pc[1] + pc[2];
  endfunction

  int b0, b1, b2, t0;
  logic [8:0] seen;

  initial begin
    reset = 1'b1; enable = 1'b1; tick = 1'b0; set_in = 3'b010;
    // Reset
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_pulse", int'(inc_pulse), 0);
      chk("rst_field", int'(active_field), 0);
      chk("rst_chord", int'(chord), 0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("rst_arm_field", int'(active_field), 1);
    set_in = 3'b000;
    @(negedge clk);
    chk("rst_tap_pulse", int'(inc_pulse), 3'b010);
    cyc(2);

    // Single tap
    b0 = pc[0]; t0 = tot();
    set_in = 3'b001;
    cyc(5);
    chk("tap_field", int'(active_field), 0);
    set_in = 3'b000;
    @(negedge clk);
    chk("tap_pulse", int'(inc_pulse), 3'b001);
    @(negedge clk);
    chk("tap_width", int'(inc_pulse), 0);
    cyc(1);
    chk("tap_count", pc[0] - b0, 1);
    chk("tap_total", tot() - t0, 1);

    // Hold with auto-repeat
    b2 = pc[2]; t0 = tot();
    set_in = 3'b100;
    @(negedge clk);
    chk("hold_field", int'(active_field), 2);
    for (int t = 0; t < 9; t++) begin
      do_tick();
      seen[t] = inc_pulse[2];
    end
    chk("hold_ticks", int'(seen), 9'b010101000);
    set_in = 3'b000;
    cyc(3);
    chk("hold_count", pc[2] - b2, 3);
    chk("hold_total", tot() - t0, 3);
    chk("hold_idle_field", int'(active_field), 0);

    // Slide
    b0 = pc[0]; b1 = pc[1]; t0 = tot();
    set_in = 3'b001;
    cyc(3);
    set_in = 3'b010;
    @(negedge clk);
    chk("slide_pulse0", int'(inc_pulse), 3'b001);
    chk("slide_field", int'(active_field), 1);
    cyc(3);
    set_in = 3'b000;
    @(negedge clk);
    chk("slide_pulse1", int'(inc_pulse), 3'b010);
    cyc(2);
    chk("slide_cnt0", pc[0] - b0, 1);
    chk("slide_cnt1", pc[1] - b1, 1);
    chk("slide_total", tot() - t0, 2);

    // Chord
    set_in = 3'b001;
    cyc(2);
    t0 = tot();
    set_in = 3'b011;
    @(negedge clk);
    chk("chord_on", int'(chord), 1);
    chk("chord_nopulse", int'(inc_pulse), 0);
    set_in = 3'b001;
    cyc(3);
    chk("chord_partial", int'(chord), 1);
    set_in = 3'b000;
    @(negedge clk);
    chk("chord_off", int'(chord), 0);
    cyc(1);
    chk("chord_total", tot() - t0, 0);
    set_in = 3'b100;
    cyc(2);
    set_in = 3'b000;
    @(negedge clk);
    chk("chord_next_tap", int'(inc_pulse), 3'b100);
    cyc(2);

    // Enable drop on release in ARMED
    set_in = 3'b010;
    cyc(2);
    t0 = tot();
    set_in = 3'b000; enable = 1'b0;
    @(negedge clk);
    chk("en_rel_nopulse", int'(inc_pulse), 0);
    cyc(2);
    enable = 1'b1;
    cyc(2);
    chk("en_rel_total", tot() - t0, 0);
    chk("en_rel_field", int'(active_field), 0);

    // Enable drop mid-REPEAT, counters restart afterwards
    b0 = pc[0];
    set_in = 3'b001;
    @(negedge clk);
    for (int t = 0; t < 5; t++) do_tick();
    cyc(1);
    chk("en_rep_before", pc[0] - b0, 1);
    enable = 1'b0;
    do_tick();
    chk("en_rep_off_pulse", int'(inc_pulse), 0);
    cyc(1);
    chk("en_rep_off_cnt", pc[0] - b0, 1);
    enable = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 3; t++) do_tick();
    cyc(1);
    chk("en_rep_restart3", pc[0] - b0, 1);
    do_tick();
    chk("en_rep_restart4", int'(inc_pulse), 3'b001);
    set_in = 3'b000;
    cyc(3);
    chk("en_rep_final", pc[0] - b0, 2);

    chk("onehot_viol", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
